// File: rtl/chr_row_fetcher.sv
// chr_row_fetcher: per-scanline text-mode sequencer.
// Fetches NUM_CHARS character codes from VRAM, turns each into one glyph row
// via the 64x8 char ROM (1-cycle synchronous read) and streams the rows out.
// Optional build macro SG4_EN: code[7]=1 selects SG4 semigraphics (no ROM read).
//
// Handshakes:
//   VRAM : o_vram_req is held with a stable o_vram_addr until a 1-cycle
//          i_vram_ack, which carries i_vram_data. Acks seen while o_vram_req
//          is low are ignored.
//   Pixel: o_pix_data/o_pix_color are valid while o_pix_valid is high and are
//          held stable until i_pix_ready is seen in the same cycle.
module chr_row_fetcher #(
   parameter int NUM_CHARS = 32,
   parameter int TOP_BLANK = 3
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_line_start,
   input  logic [3:0]  i_cell_row,
   input  logic [15:0] i_vram_base,
   output logic        o_vram_req,
   output logic [15:0] o_vram_addr,
   input  logic        i_vram_ack,
   input  logic [7:0]  i_vram_data,
   output logic [9:0]  o_rom_addr,
   output logic        o_rom_cs,
   input  logic [7:0]  i_rom_dout,
   output logic [7:0]  o_pix_data,
   output logic [2:0]  o_pix_color,
   output logic        o_pix_valid,
   input  logic        i_pix_ready,
   output logic        o_busy,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_VREQ = 3'd1,
      S_ROMA = 3'd2,
      S_ROMW = 3'd3,
      S_PUSH = 3'd4
   } state_t;

   localparam logic [4:0] LP_BLANK_LO = 5'(TOP_BLANK);
   localparam logic [4:0] LP_BLANK_HI = 5'(TOP_BLANK + 7);
   localparam logic [5:0] LP_LAST_IDX = 6'(NUM_CHARS - 1);

   state_t      r_state;
   logic [3:0]  r_cell_row;
   logic [5:0]  r_idx;
   logic [6:0]  r_code;
   logic        r_is_sg;
   logic [7:0]  r_g;
   logic [2:0]  r_gc;
   logic        r_vram_req;
   logic [15:0] r_vram_addr;
   logic        r_rom_cs;
   logic [9:0]  r_rom_addr;
   logic [7:0]  r_pix_data;
   logic [2:0]  r_pix_color;
   logic        r_pix_valid;
   logic        r_busy;

   logic        w_sg_in;
   logic        w_blank;
   logic        w_top;
   logic [2:0]  w_glyph_row;
   logic [7:0]  w_g;
   logic [2:0]  w_gc;
   logic        w_out_free;
   logic        w_accept;

`ifdef SG4_EN
   assign w_sg_in = i_vram_data[7];
`else
   // code[7] has no meaning when semigraphics are not built in
   assign w_sg_in = i_vram_data[7] & 1'b0;
`endif

   assign w_blank     = ({1'b0, r_cell_row} < LP_BLANK_LO) || ({1'b0, r_cell_row} >= LP_BLANK_HI);
   assign w_top       = (r_cell_row < 4'd6);
   assign w_glyph_row = r_cell_row[2:0] - 3'(TOP_BLANK);
   assign w_accept    = r_pix_valid & i_pix_ready;
   assign w_out_free  = ~r_pix_valid | i_pix_ready;

   // Pixel byte formation from the ROM row or the SG4 quadrant bits
   always_comb begin
      w_g  = 8'h00;
      w_gc = 3'd0;
      if (r_is_sg) begin
         w_g  = w_top ? {{4{r_code[3]}}, {4{r_code[2]}}} : {{4{r_code[1]}}, {4{r_code[0]}}};
         w_gc = r_code[6:4];
      end else begin
         w_g = w_blank ? 8'h00 : i_rom_dout;
         if (r_code[6]) begin
            w_g = ~w_g;
         end
      end
   end

   // Sequencer FSM with registered outputs; line_start aborts and restarts from any state
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_cell_row  <= 4'd0;
         r_idx       <= 6'd0;
         r_code      <= 7'd0;
         r_is_sg     <= 1'b0;
         r_g         <= 8'h00;
         r_gc        <= 3'd0;
         r_vram_req  <= 1'b0;
         r_vram_addr <= 16'h0000;
         r_rom_cs    <= 1'b0;
         r_rom_addr  <= 10'd0;
         r_pix_data  <= 8'h00;
         r_pix_color <= 3'd0;
         r_pix_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (i_line_start) begin
         r_state     <= S_VREQ;
         r_cell_row  <= i_cell_row;
         r_vram_addr <= i_vram_base;
         r_idx       <= 6'd0;
         r_busy      <= 1'b1;
         r_pix_valid <= 1'b0;
         r_rom_cs    <= 1'b0;
         // An aborted request gets one cycle with req low so its late ack is ignored
         r_vram_req  <= ~r_vram_req;
      end else begin
         r_rom_cs <= 1'b0;
         if (w_accept) begin
            r_pix_valid <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_busy <= 1'b0;
               end
            end
            S_VREQ: begin
               if (!r_vram_req) begin
                  r_vram_req <= 1'b1;
               end else if (i_vram_ack) begin
                  r_vram_req <= 1'b0;
                  r_code     <= i_vram_data[6:0];
                  r_is_sg    <= w_sg_in;
                  if (w_sg_in) begin
                     r_state <= S_ROMW;
                  end else begin
                     r_state    <= S_ROMA;
                     r_rom_cs   <= 1'b1;
                     r_rom_addr <= {1'b0, i_vram_data[5:0], w_glyph_row};
                  end
               end
            end
            S_ROMA: begin
               r_state <= S_ROMW;
            end
            S_ROMW: begin
               r_g     <= w_g;
               r_gc    <= w_gc;
               r_state <= S_PUSH;
            end
            S_PUSH: begin
               if (w_out_free) begin
                  r_pix_data  <= r_g;
                  r_pix_color <= r_gc;
                  r_pix_valid <= 1'b1;
                  if (r_idx == LP_LAST_IDX) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state     <= S_VREQ;
                     r_idx       <= r_idx + 6'd1;
                     r_vram_req  <= 1'b1;
                     r_vram_addr <= r_vram_addr + 16'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_vram_req  = r_vram_req;
   assign o_vram_addr = r_vram_addr;
   assign o_rom_cs    = r_rom_cs;
   assign o_rom_addr  = r_rom_addr;
   assign o_pix_data  = r_pix_data;
   assign o_pix_color = r_pix_color;
   assign o_pix_valid = r_pix_valid;
   assign o_busy      = r_busy;
   assign o_dbg_state = r_state;

endmodule
